// File: rtl/mem_controller.sv
// Round-robin arbiter that funnels per-lane valid/ready read and write requests
// onto a single external memory port and relays each result back to its lane.
module mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready
);

  localparam int IDXW = $clog2(NUM_CONSUMERS);
  localparam bit WE   = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                   state_q, state_d;
  logic [IDXW-1:0]          k_q, k_d;
  logic [IDXW-1:0]          rr_q, rr_d;
  logic                     mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]     mem_read_address_q, mem_read_address_d;
  logic                     mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]     mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]     mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0] rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0] wr_ready_q, wr_ready_d;
  logic [DATA_BITS-1:0]     rd_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     rd_data_d [NUM_CONSUMERS];

  logic [ADDR_BITS-1:0]     rd_addr_lane [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     wr_addr_lane [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     wr_data_lane [NUM_CONSUMERS];

  logic                     found;
  logic                     win_read;
  logic [IDXW-1:0]          winner;

  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_lane
    assign rd_addr_lane[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_addr_lane[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_data_lane[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = rd_data_q[g];
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_write_ready = wr_ready_q;
  assign mem_read_valid       = mem_read_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;

  // Scan from rr_q with explicit wrap so non-power-of-2 lane counts work; read beats write on a lane.
  always_comb begin
    int              idx;
    logic [IDXW-1:0] lane;
    found    = 1'b0;
    win_read = 1'b0;
    winner   = '0;
    idx      = 0;
    lane     = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
      lane = IDXW'(idx);
      if (!found && (consumer_read_valid[lane] || (WE && consumer_write_valid[lane]))) begin
        found    = 1'b1;
        winner   = lane;
        win_read = consumer_read_valid[lane];
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    k_d                 = k_q;
    rr_d                = rr_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    rd_ready_d          = rd_ready_q;
    wr_ready_d          = wr_ready_q;
    rd_data_d           = rd_data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          k_d  = winner;
          rr_d = (winner == IDXW'(NUM_CONSUMERS - 1)) ? '0 : winner + 1'b1;
          if (win_read) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = rd_addr_lane[winner];
            state_d            = READ_WAITING;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = wr_addr_lane[winner];
            mem_write_data_d    = wr_data_lane[winner];
            state_d             = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          mem_read_valid_d = 1'b0;
          rd_ready_d[k_q]  = 1'b1;
          rd_data_d[k_q]   = mem_read_data;
          state_d          = READ_RELAYING;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mem_write_valid_d = 1'b0;
          wr_ready_d[k_q]   = 1'b1;
          state_d           = WRITE_RELAYING;
        end
      end
      READ_RELAYING: begin
        if (!consumer_read_valid[k_q]) begin
          rd_ready_d[k_q] = 1'b0;
          state_d         = IDLE;
        end
      end
      WRITE_RELAYING: begin
        if (!consumer_write_valid[k_q]) begin
          wr_ready_d[k_q] = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= IDLE;
      k_q                 <= '0;
      rr_q                <= '0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      rd_ready_q          <= '0;
      wr_ready_q          <= '0;
      for (int j = 0; j < NUM_CONSUMERS; j++) rd_data_q[j] <= '0;
    end else begin
      state_q             <= state_d;
      k_q                 <= k_d;
      rr_q                <= rr_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      rd_ready_q          <= rd_ready_d;
      wr_ready_q          <= wr_ready_d;
      for (int j = 0; j < NUM_CONSUMERS; j++) rd_data_q[j] <= rd_data_d[j];
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: a read/write instance plus a read-only instance
// sharing clock and reset, with the bench acting as both consumers and memory.
module tb_mem_controller;

  logic        clk;
  logic        reset;

  logic [3:0]  rv, wv, readReady, writeReady;
  logic [31:0] raddr, waddr, wdata, readData;
  logic        memReadValid, memReadReady, memWriteValid, memWriteReady;
  logic [7:0]  memReadAddress, memReadData, memWriteAddress, memWriteData;

  logic [3:0]  roRv, roWv, roReadReady, roWriteReady;
  logic [31:0] roRaddr, roWaddr, roWdata, roReadData;
  logic        roMemReadValid, roMemReadReady, roMemWriteValid, roMemWriteReady;
  logic [7:0]  roMemReadAddress, roMemReadData, roMemWriteAddress, roMemWriteData;

  int testsRun    = 0;
  int testsFailed = 0;
  int bothHigh    = 0;
  int roWriteSeen = 0;

  mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .WRITE_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(raddr),
    .consumer_read_ready(readReady), .consumer_read_data(readData),
    .consumer_write_valid(wv), .consumer_write_address(waddr),
    .consumer_write_data(wdata), .consumer_write_ready(writeReady),
    .mem_read_valid(memReadValid), .mem_read_address(memReadAddress),
    .mem_read_ready(memReadReady), .mem_read_data(memReadData),
    .mem_write_valid(memWriteValid), .mem_write_address(memWriteAddress),
    .mem_write_data(memWriteData), .mem_write_ready(memWriteReady)
  );

  mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .WRITE_ENABLE(0)) dutRo (
    .clk(clk), .reset(reset),
    .consumer_read_valid(roRv), .consumer_read_address(roRaddr),
    .consumer_read_ready(roReadReady), .consumer_read_data(roReadData),
    .consumer_write_valid(roWv), .consumer_write_address(roWaddr),
    .consumer_write_data(roWdata), .consumer_write_ready(roWriteReady),
    .mem_read_valid(roMemReadValid), .mem_read_address(roMemReadAddress),
    .mem_read_ready(roMemReadReady), .mem_read_data(roMemReadData),
    .mem_write_valid(roMemWriteValid), .mem_write_address(roMemWriteAddress),
    .mem_write_data(roMemWriteData), .mem_write_ready(roMemWriteReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background watchers for properties that must hold on every cycle.
  always @(negedge clk) begin
    if (memReadValid && memWriteValid) bothHigh++;
    if (roMemWriteValid || (roWriteReady != 4'b0)) roWriteSeen++;
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic serveRead(input string tag, input logic [7:0] expAddr, input int lane, input logic [7:0] rdata);
    for (int c = 0; c < 10 && !(memReadValid || memWriteValid); c++) applyStimulus(1);
    checkOutput({tag, "_rd_issued"}, {30'd0, memWriteValid, memReadValid}, 32'd1);
    checkOutput({tag, "_rd_addr"}, {24'd0, memReadAddress}, {24'd0, expAddr});
    memReadReady = 1'b1;
    memReadData  = rdata;
    applyStimulus(1);
    memReadReady = 1'b0;
    checkOutput({tag, "_rd_ready"}, {31'd0, readReady[lane]}, 32'd1);
    checkOutput({tag, "_rd_data"}, {24'd0, readData[lane*8 +: 8]}, {24'd0, rdata});
    rv[lane] = 1'b0;
    applyStimulus(1);
    checkOutput({tag, "_rd_ready_fall"}, {31'd0, readReady[lane]}, 32'd0);
  endtask

  task automatic serveWrite(input string tag, input logic [7:0] expAddr, input logic [7:0] expData, input int lane);
    for (int c = 0; c < 10 && !(memReadValid || memWriteValid); c++) applyStimulus(1);
    checkOutput({tag, "_wr_issued"}, {30'd0, memWriteValid, memReadValid}, 32'd2);
    checkOutput({tag, "_wr_addr"}, {24'd0, memWriteAddress}, {24'd0, expAddr});
    checkOutput({tag, "_wr_data"}, {24'd0, memWriteData}, {24'd0, expData});
    memWriteReady = 1'b1;
    applyStimulus(1);
    memWriteReady = 1'b0;
    checkOutput({tag, "_wr_ready"}, {31'd0, writeReady[lane]}, 32'd1);
    wv[lane] = 1'b0;
    applyStimulus(1);
    checkOutput({tag, "_wr_ready_fall"}, {31'd0, writeReady[lane]}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
    memReadReady = 1'b0; memReadData = '0; memWriteReady = 1'b0;
    roRv = '0; roWv = '0; roRaddr = '0; roWaddr = '0; roWdata = '0;
    roMemReadReady = 1'b0; roMemReadData = '0; roMemWriteReady = 1'b0;

    applyStimulus(2);
    checkOutput("reset_mem_valids", {30'd0, memWriteValid, memReadValid}, 32'd0);
    checkOutput("reset_ready", {24'd0, writeReady, readReady}, 32'd0);
    checkOutput("reset_read_data", readData, 32'd0);
    reset = 1'b0;

    // Single read on lane 2 with a two-cycle memory response.
    rv[2] = 1'b1;
    raddr[23:16] = 8'h15;
    applyStimulus(1);
    checkOutput("single_valid_rise", {31'd0, memReadValid}, 32'd1);
    checkOutput("single_addr", {24'd0, memReadAddress}, 32'h15);
    applyStimulus(1);
    checkOutput("single_valid_hold", {31'd0, memReadValid}, 32'd1);
    checkOutput("single_addr_hold", {24'd0, memReadAddress}, 32'h15);
    memReadReady = 1'b1;
    memReadData  = 8'hA7;
    applyStimulus(1);
    memReadReady = 1'b0;
    checkOutput("single_ready", {28'd0, readReady}, 32'h4);
    checkOutput("single_data", readData, 32'h00A7_0000);
    checkOutput("single_valid_fall", {31'd0, memReadValid}, 32'd0);
    applyStimulus(1);
    checkOutput("single_ready_hold", {28'd0, readReady}, 32'h4);
    rv[2] = 1'b0;
    applyStimulus(1);
    checkOutput("single_ready_fall", {28'd0, readReady}, 32'h0);
    applyStimulus(1);
    checkOutput("single_idle", {30'd0, memWriteValid, memReadValid}, 32'd0);

    // Round robin from a fresh reset: order 0,1,3 then lane 0 again.
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    raddr = 32'h13_00_11_10;
    rv = 4'b1011;
    serveRead("rr_lane0", 8'h10, 0, 8'hC0);
    rv[0] = 1'b1;
    serveRead("rr_lane1", 8'h11, 1, 8'hC1);
    serveRead("rr_lane3", 8'h13, 3, 8'hC3);
    serveRead("rr_lane0_again", 8'h10, 0, 8'hC4);
    checkOutput("rr_data_all", readData, 32'hC300_C1C4);

    // Same-lane read/write collision: read first, write on a later grant.
    raddr[15:8] = 8'h04;
    waddr[15:8] = 8'h04;
    wdata[15:8] = 8'h3C;
    rv[1] = 1'b1;
    wv[1] = 1'b1;
    serveRead("coll", 8'h04, 1, 8'h5A);
    serveWrite("coll", 8'h04, 8'h3C, 1);

    // Read-only instance ignores writes while still serving reads.
    roWv[0] = 1'b1;
    roWaddr[7:0] = 8'h40;
    roWdata[7:0] = 8'hEE;
    roRv[1] = 1'b1;
    roRaddr[15:8] = 8'h22;
    applyStimulus(1);
    checkOutput("ro_rd_valid", {31'd0, roMemReadValid}, 32'd1);
    checkOutput("ro_rd_addr", {24'd0, roMemReadAddress}, 32'h22);
    roMemReadReady = 1'b1;
    roMemReadData  = 8'h99;
    applyStimulus(1);
    roMemReadReady = 1'b0;
    checkOutput("ro_rd_ready", {28'd0, roReadReady}, 32'h2);
    checkOutput("ro_rd_data", roReadData, 32'h0000_9900);
    roRv[1] = 1'b0;
    applyStimulus(1);
    checkOutput("ro_rd_ready_fall", {28'd0, roReadReady}, 32'h0);
    applyStimulus(17);
    checkOutput("ro_no_grant", {31'd0, roMemReadValid}, 32'd0);
    checkOutput("ro_write_never", roWriteSeen, 32'd0);
    roWv[0] = 1'b0;

    // Asynchronous reset while a read is outstanding.
    rv[2] = 1'b1;
    raddr[23:16] = 8'h2A;
    applyStimulus(1);
    checkOutput("rst_pre_valid", {31'd0, memReadValid}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_async_valid", {31'd0, memReadValid}, 32'd0);
    checkOutput("rst_async_addr", {24'd0, memReadAddress}, 32'd0);
    checkOutput("rst_async_data", readData, 32'd0);
    rv = 4'b1010;
    raddr = 32'h33_00_31_00;
    #1;
    reset = 1'b0;
    serveRead("rst_first", 8'h31, 1, 8'h77);

    // Lane 3 drops its request during the wait; the read still completes.
    for (int c = 0; c < 10 && !memReadValid; c++) applyStimulus(1);
    checkOutput("drop_addr", {24'd0, memReadAddress}, 32'h33);
    rv[3] = 1'b0;
    applyStimulus(1);
    checkOutput("drop_still_waiting", {31'd0, memReadValid}, 32'd1);
    memReadReady = 1'b1;
    memReadData  = 8'hE1;
    applyStimulus(1);
    memReadReady = 1'b0;
    checkOutput("drop_ready", {28'd0, readReady}, 32'h8);
    checkOutput("drop_data", readData, 32'hE100_7700);
    applyStimulus(1);
    checkOutput("drop_ready_one_cycle", {28'd0, readReady}, 32'h0);
    applyStimulus(2);
    checkOutput("drop_idle", {30'd0, memWriteValid, memReadValid}, 32'd0);

    checkOutput("never_both_valid", bothHigh, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Responder end of the valid/ready memory-request protocol that GPU cores, fetchers and LSUs initiate.
- Accepts read and write requests from NUM_CONSUMERS requesters and arbitrates them round-robin onto one external memory port, which uses the same protocol.
- Relays each result back with a four-phase handshake.
- Two instances are planned: one for data memory (WRITE_ENABLE=1) and one for program memory (WRITE_ENABLE=0).

Parameters:
- ADDR_BITS, 8, address width.
- DATA_BITS, 8, data width.
- NUM_CONSUMERS, 4, number of requester lanes (at least 2).
- WRITE_ENABLE, 1, 1 = write path present; 0 = read-only.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-lane read request.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  flattened; lane k occupies bits [k*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  per-lane read completion.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  flattened per-lane read data.
- consumer_write_valid  in  NUM_CONSUMERS  per-lane write request.
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  flattened.
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  flattened.
- consumer_write_ready  out  NUM_CONSUMERS  per-lane write completion.
- mem_read_valid  out  1  external read request.
- mem_read_address  out  ADDR_BITS  external read address.
- mem_read_ready  in  1  external read done; mem_read_data is valid in the same cycle.
- mem_read_data  in  DATA_BITS  external read data.
- mem_write_valid  out  1  external write request.
- mem_write_address  out  ADDR_BITS  external write address.
- mem_write_data  out  DATA_BITS  external write data.
- mem_write_ready  in  1  external write done.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state): every output = 0, state = IDLE, rr_ptr = 0, all transaction latches cleared.
- State machine: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING. Registered current-lane index is k.
- IDLE:
  - Scan lanes rr_ptr, rr_ptr+1, … mod NUM_CONSUMERS.
  - The first lane with read_valid, or with write_valid when WRITE_ENABLE=1, wins.
  - If the winning lane has both read and write valid, the read is served first; the write is picked up on a later grant.
  - On a grant: latch address (and write data), set k = winner, set rr_ptr = (winner+1) mod NUM_CONSUMERS.
  - Read grant: next cycle mem_read_valid=1 and mem_read_address=latched address; go to READ_WAITING.
  - Write grant: mem_write_valid/address/data the same way; go to WRITE_WAITING.
  - Latency: a request sampled at edge N appears on the memory port after edge N.
- READ_WAITING:
  - Hold mem_read_valid and address stable until mem_read_ready=1.
  - On that edge: mem_read_valid=0, consumer_read_ready[k]=1, consumer_read_data[k]=mem_read_data; go to READ_RELAYING.
- WRITE_WAITING:
  - Same as READ_WAITING, on mem_write_ready; sets consumer_write_ready[k]=1; go to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING:
  - Hold the ready and data until the consumer deasserts its matching valid.
  - On the edge where that valid is sampled 0: ready[k]=0, go to IDLE.
  - If valid is already 0 on entry, ready is high for exactly one cycle.
- consumer_read_data[j] keeps its last value when not being updated. Only lane k's data field ever changes.
- Only one external transaction is in flight at a time. mem_read_valid and mem_write_valid are never both 1.
- A consumer that drops valid during *_WAITING does not abort the transaction: the memory access completes and the relay proceeds as described above.
- Minimum back-to-back spacing is 4 cycles per transaction when memory answers in 1 cycle: grant, wait, relay, idle.
- WRITE_ENABLE=0: write inputs are ignored; mem_write_* and consumer_write_ready are constant 0.
- NUM_CONSUMERS that is not a power of 2: rr_ptr wraps explicitly from NUM_CONSUMERS-1 to 0.

Test Plan:
- Single read: lane 2 reads addr 0x15; memory returns 0xA7 after 2 cycles → mem_read_valid rises 1 cycle after the request and holds addr 0x15; read_ready[2]=1 with data[2]=0xA7; ready falls 1 cycle after lane 2 drops valid; state returns to IDLE.
- Round-robin: lanes 0,1,3 assert reads simultaneously at reset (rr_ptr=0) → service order 0,1,3. Lane 0 re-requests immediately → next order is 0 only after lane 3; no lane is starved.
- Read/write collision: lane 1 asserts both read of 0x04 and write of 0x04=0x3C → read issued first; write issued on a subsequent grant; mem_read_valid and mem_write_valid are never high together.
- WRITE_ENABLE=0: lane 0 write_valid held for 20 cycles → no mem_write_valid, write_ready[0] stays 0; a concurrent read on lane 1 completes normally.
- Reset mid-operation: assert reset during READ_WAITING → all outputs 0 asynchronously (before the next edge). After release, the first request is granted scanning from lane 0.
- Early drop: lane 3 drops read_valid while in READ_WAITING → external read still completes; read_ready[3] high for exactly 1 cycle; then IDLE.
